// File: rtl/eth_frame_sender.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_sender
// Purpose  : Serialises a Tx-buffer frame as preamble, SFD, data, pad, FCS.
// Revision : 1.0  initial release
// ============================================================================
module eth_frame_sender #(
   parameter int ADDR_W       = 11,
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int MAX_FRAME    = 1514,
   parameter int IFG_CYCLES   = 12
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Tx_Start,
   input  logic [10:0]       Tx_NUM_Data,
   output logic [ADDR_W-1:0] Tx_Buf_Addr,
   input  logic [15:0]       Tx_Buf_Data,
   output logic [7:0]        Byte_Data,
   output logic              Byte_Valid,
   input  logic              Byte_Ready,
   output logic              Byte_Last,
   output logic              Busy,
   output logic              Done,
   output logic              Start_Err
);

   localparam logic [10:0] c_min_len   = 11'd14;
   localparam logic [10:0] c_max_len   = 11'(MAX_FRAME);
   localparam logic [10:0] c_min_frame = 11'(MIN_FRAME);
   localparam logic [10:0] c_pre_last  = 11'(PREAMBLE_LEN - 1);
   localparam logic [10:0] c_pad_last  = 11'(MIN_FRAME - 1);
   localparam logic [10:0] c_ifg_last  = 11'(IFG_CYCLES - 1);
   localparam logic [31:0] c_crc_poly  = 32'hEDB88320;

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
   } state_t;

   state_t      r_state;
   logic [10:0] r_len;
   logic [10:0] r_cnt;
   logic [7:0]  r_lo;
   logic [31:0] r_crc;
   logic        w_acc;
   logic [31:0] w_crc_next;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
      return c;
   endfunction

   assign w_acc      = Byte_Valid & Byte_Ready;
   assign w_crc_next = crc_byte(r_crc, Byte_Data);

   // Byte_Data always holds the byte on offer; it is replaced only on acceptance.
   // Tx_Buf_Addr runs one word ahead so the next high byte is ready on time.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_cnt       <= '0;
         r_lo        <= '0;
         r_crc       <= 32'hFFFF_FFFF;
         Tx_Buf_Addr <= '0;
         Byte_Data   <= 8'h00;
         Byte_Valid  <= 1'b0;
         Byte_Last   <= 1'b0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Start_Err   <= 1'b0;
      end else begin
         Done      <= 1'b0;
         Start_Err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Tx_Start) begin
                  if (Tx_NUM_Data >= c_min_len && Tx_NUM_Data <= c_max_len) begin
                     r_state     <= S_PRE;
                     r_len       <= Tx_NUM_Data;
                     r_cnt       <= '0;
                     r_crc       <= 32'hFFFF_FFFF;
                     Tx_Buf_Addr <= '0;
                     Byte_Data   <= 8'h55;
                     Byte_Valid  <= 1'b1;
                     Busy        <= 1'b1;
                  end else begin
                     Start_Err <= 1'b1;
                  end
               end
            end
            S_PRE: begin
               if (w_acc) begin
                  if (r_cnt == c_pre_last) begin
                     r_state   <= S_SFD;
                     Byte_Data <= 8'hD5;
                  end else begin
                     r_cnt <= r_cnt + 11'd1;
                  end
               end
            end
            S_SFD: begin
               if (w_acc) begin
                  r_state     <= S_DATA;
                  r_cnt       <= '0;
                  Byte_Data   <= Tx_Buf_Data[15:8];
                  r_lo        <= Tx_Buf_Data[7:0];
                  Tx_Buf_Addr <= ADDR_W'(1);
               end
            end
            S_DATA: begin
               if (w_acc) begin
                  r_crc <= w_crc_next;
                  if (r_cnt == r_len - 11'd1) begin
                     if (r_len < c_min_frame) begin
                        r_state   <= S_PAD;
                        r_cnt     <= r_len;
                        Byte_Data <= 8'h00;
                     end else begin
                        r_state   <= S_FCS;
                        r_cnt     <= '0;
                        Byte_Data <= ~w_crc_next[7:0];
                     end
                  end else begin
                     r_cnt <= r_cnt + 11'd1;
                     if (!r_cnt[0]) begin
                        Byte_Data <= r_lo;
                     end else begin
                        Byte_Data   <= Tx_Buf_Data[15:8];
                        r_lo        <= Tx_Buf_Data[7:0];
                        Tx_Buf_Addr <= Tx_Buf_Addr + ADDR_W'(1);
                     end
                  end
               end
            end
            S_PAD: begin
               if (w_acc) begin
                  r_crc <= w_crc_next;
                  if (r_cnt == c_pad_last) begin
                     r_state   <= S_FCS;
                     r_cnt     <= '0;
                     Byte_Data <= ~w_crc_next[7:0];
                  end else begin
                     r_cnt <= r_cnt + 11'd1;
                  end
               end
            end
            S_FCS: begin
               // r_crc holds the final remainder and shifts one byte per accepted FCS byte.
               if (w_acc) begin
                  r_crc <= {8'h00, r_crc[31:8]};
                  if (r_cnt == 11'd3) begin
                     r_state    <= S_IFG;
                     r_cnt      <= '0;
                     Byte_Valid <= 1'b0;
                     Byte_Last  <= 1'b0;
                     Byte_Data  <= 8'h00;
                     Done       <= 1'b1;
                  end else begin
                     r_cnt     <= r_cnt + 11'd1;
                     Byte_Data <= ~r_crc[15:8];
                     Byte_Last <= (r_cnt == 11'd2);
                  end
               end
            end
            S_IFG: begin
               if (r_cnt == c_ifg_last) begin
                  r_state <= S_IDLE;
                  Busy    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 11'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (Tx_Start && r_state != S_IDLE)
            Start_Err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_frame_sender
// Purpose  : Directed and random frames checked against a byte-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_frame_sender;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Tx_Start = 1'b0;
   logic        Byte_Ready = 1'b1;
   logic [10:0] Tx_NUM_Data = '0;
   logic [10:0] Tx_Buf_Addr;
   logic [15:0] Tx_Buf_Data = '0;
   logic [7:0]  Byte_Data;
   logic        Byte_Valid, Byte_Last, Busy, Done, Start_Err;

   logic [15:0] mem [0:2047];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          ready_mode = 0;
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   logic [31:0] exp_fcs;
   int          last_cnt, last_idx, last_cyc, done_cyc, viol, err_cnt;
   logic        in_frame, stall_prev;
   logic [7:0]  stall_byte;

   eth_frame_sender dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Tx_Start    (Tx_Start),
      .Tx_NUM_Data (Tx_NUM_Data),
      .Tx_Buf_Addr (Tx_Buf_Addr),
      .Tx_Buf_Data (Tx_Buf_Data),
      .Byte_Data   (Byte_Data),
      .Byte_Valid  (Byte_Valid),
      .Byte_Ready  (Byte_Ready),
      .Byte_Last   (Byte_Last),
      .Busy        (Busy),
      .Done        (Done),
      .Start_Err   (Start_Err)
   );

   always #5 Clock = ~Clock;

   // Synchronous buffer RAM: data for an address appears one cycle later.
   always @(posedge Clock) begin
      cyc         <= cyc + 1;
      Tx_Buf_Data <= mem[Tx_Buf_Addr];
   end

   always @(posedge Clock) begin
      #1;
      case (ready_mode)
         1:       Byte_Ready = ~Byte_Ready;
         2:       Byte_Ready = 1'($urandom_range(0, 1));
         default: Byte_Ready = 1'b1;
      endcase
   end

   always @(negedge Clock) begin
      if (Byte_Valid && Byte_Ready) begin
         rx_q.push_back(Byte_Data);
         in_frame = 1'b1;
         if (Byte_Last) begin
            last_cnt++;
            last_idx = rx_q.size() - 1;
            last_cyc = cyc;
            in_frame = 1'b0;
         end
      end else if (in_frame && !Byte_Valid) begin
         viol++;
      end
      if (stall_prev && Byte_Valid && Byte_Data != stall_byte) viol++;
      if (Byte_Valid && !Busy) viol++;
      stall_prev = Byte_Valid && !Byte_Ready;
      stall_byte = Byte_Data;
      if (Done) done_cyc = cyc;
      if (Start_Err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      rx_q.delete();
      last_cnt   = 0;
      last_idx   = -1;
      last_cyc   = -100;
      done_cyc   = -200;
      viol       = 0;
      err_cnt    = 0;
      in_frame   = 1'b0;
      stall_prev = 1'b0;
   endtask

   // Expected wire image: preamble, SFD, payload, zero pad, bit-serial CRC-32.
   task automatic prep_frame(input int n, input bit incr);
      logic [7:0]  pay [0:2047];
      logic [7:0]  b;
      logic [31:0] c;
      int          body;
      for (int i = 0; i <= n; i++) pay[i] = incr ? 8'(i) : 8'($urandom);
      for (int k = 0; k < (n + 1) / 2; k++) mem[k] = {pay[2*k], pay[2*k+1]};
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      body = (n < 60) ? 60 : n;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < body; i++) begin
         b = (i < n) ? pay[i] : 8'h00;
         exp_q.push_back(b);
         for (int j = 0; j < 8; j++)
            c = (c[0] ^ b[j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      exp_fcs = ~c;
      for (int j = 0; j < 4; j++) exp_q.push_back(exp_fcs[8*j +: 8]);
   endtask

   task automatic start_pulse(input int n);
      @(posedge Clock); #1;
      Tx_Start    = 1'b1;
      Tx_NUM_Data = 11'(n);
      @(posedge Clock); #1;
      Tx_Start    = 1'b0;
      Tx_NUM_Data = 11'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (i < budget && !Done) begin
         @(negedge Clock); #1;
         i++;
      end
      check("done_seen", {31'd0, Done}, 32'd1);
   endtask

   task automatic wait_bytes(input int cnt, input int budget);
      int i = 0;
      while (rx_q.size() < cnt && i < budget) begin
         @(negedge Clock); #1;
         i++;
      end
      check("byte_wait", 32'(rx_q.size() >= cnt), 32'd1);
   endtask

   task automatic check_ifg();
      int cnt = 0;
      while (Busy && cnt < 40) begin
         cnt++;
         @(negedge Clock); #1;
      end
      check("ifg_busy_cycles", 32'(cnt), 32'd12);
   endtask

   task automatic check_frame();
      int          mism = 0;
      int          s;
      logic [31:0] fcs_got = '0;
      s = rx_q.size();
      check("frame_len", 32'(s), 32'(exp_q.size()));
      for (int i = 0; i < s && i < exp_q.size(); i++)
         if (rx_q[i] !== exp_q[i]) mism++;
      check("frame_byte_mismatches", 32'(mism), 32'd0);
      if (s >= 4) fcs_got = {rx_q[s-1], rx_q[s-2], rx_q[s-3], rx_q[s-4]};
      check("fcs", fcs_got, exp_fcs);
      check("last_count", 32'(last_cnt), 32'd1);
      check("last_index", 32'(last_idx), 32'(exp_q.size() - 1));
      check("done_delay", 32'(done_cyc - last_cyc), 32'd1);
      check("handshake_viol", 32'(viol), 32'd0);
   endtask

   task automatic run_frame(input int n, input bit incr, input int mode);
      ready_mode = mode;
      prep_frame(n, incr);
      clear_mon();
      start_pulse(n);
      wait_done(4 * (n + 80) + 50);
      check_ifg();
      check_frame();
      ready_mode = 0;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
      clear_mon();
      Reset = 1'b1;
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      @(negedge Clock); #1;
      check("rst_valid", {31'd0, Byte_Valid}, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_data", {24'd0, Byte_Data}, 32'd0);
      check("rst_addr", {21'd0, Tx_Buf_Addr}, 32'd0);
      check("rst_done", {30'd0, Done, Start_Err}, 32'd0);
      check("rst_last", {31'd0, Byte_Last}, 32'd0);

      // Minimum-size frame with counting payload, then padded ARP-size, then odd length with stalls.
      run_frame(60, 1'b1, 0);
      run_frame(42, 1'b0, 0);
      run_frame(61, 1'b0, 1);

      // Out-of-range lengths are rejected without emitting anything.
      clear_mon();
      start_pulse(1515);
      @(negedge Clock); #1;
      check("err_long_pulse", {31'd0, Start_Err}, 32'd1);
      check("err_long_busy", {31'd0, Busy}, 32'd0);
      start_pulse(13);
      @(negedge Clock); #1;
      check("err_short_pulse", {31'd0, Start_Err}, 32'd1);
      repeat (20) @(negedge Clock);
      #1;
      check("err_no_bytes", 32'(rx_q.size()), 32'd0);
      check("err_pulse_count", 32'(err_cnt), 32'd2);
      run_frame(1514, 1'b0, 0);

      // Start while busy, and start in the last busy IFG cycle.
      ready_mode = 0;
      prep_frame(100, 1'b0);
      clear_mon();
      start_pulse(100);
      wait_bytes(18, 200);
      start_pulse(60);
      @(negedge Clock); #1;
      check("busy_start_err", {31'd0, Start_Err}, 32'd1);
      wait_done(1000);
      repeat (11) @(posedge Clock);
      #1;
      check("ifg_last_busy", {31'd0, Busy}, 32'd1);
      Tx_Start    = 1'b1;
      Tx_NUM_Data = 11'd60;
      @(posedge Clock); #1;
      Tx_Start = 1'b0;
      @(negedge Clock); #1;
      check("ifg_exit_start_err", {31'd0, Start_Err}, 32'd1);
      check("ifg_exit_busy", {31'd0, Busy}, 32'd0);
      repeat (5) @(negedge Clock);
      #1;
      check("ifg_exit_no_frame", {31'd0, Byte_Valid}, 32'd0);
      check_frame();

      // Reset in the middle of DATA, then a clean frame.
      prep_frame(60, 1'b0);
      clear_mon();
      start_pulse(60);
      wait_bytes(28, 200);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      @(negedge Clock); #1;
      check("midrst_valid", {31'd0, Byte_Valid}, 32'd0);
      check("midrst_busy", {31'd0, Busy}, 32'd0);
      check("midrst_data", {24'd0, Byte_Data}, 32'd0);
      check("midrst_addr", {21'd0, Tx_Buf_Addr}, 32'd0);
      run_frame(60, 1'b0, 0);

      for (int t = 0; t < 6; t++)
         run_frame(int'($urandom_range(14, 200)), 1'b0, int'($urandom_range(0, 2)));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
